// File: rtl/lsu_if.sv
// Data-memory request/response bus between the LSU (master) and memory (slave).
// Request side is held until dmem_gnt; read data returns on dmem_rvalid.
// Either side may stall indefinitely; the master keeps the request stable.
interface lsu_if #(
    parameter int XLEN = 32
);
    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [3:0]      dmem_be;
    logic [XLEN-1:0] dmem_wdata;
    logic            dmem_gnt;
    logic            dmem_rvalid;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/lsu.sv
// Load/store unit: aligns stores, extends loads, flags misaligned/illegal ops.
// Latency: store 2 cycles min, load 3 cycles accept-to-wb_valid, exception 1 cycle.
// Backpressure: ex_ready low while an access is outstanding; gnt/rvalid stalls hold state.
module lsu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic            is_store,
    input  logic [2:0]      mem_op,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] store_data,
    input  logic [4:0]      rd_addr,
    lsu_if.master           dmem,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            exc_valid,
    output logic [1:0]      exc_cause,
    output logic [XLEN-1:0] exc_addr,
    output logic            busy
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t          state, state_nxt;
    logic            acc;
    logic            op_illegal;
    logic            op_misal;
    logic [3:0]      acc_be;
    logic [XLEN-1:0] acc_wdata;
    logic [2:0]      op_q;
    logic [1:0]      off_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] lane;
    logic [XLEN-1:0] ld_ext;

    assign ex_ready      = (state == S_IDLE);
    assign busy          = ~ex_ready;
    assign acc           = ex_valid & ex_ready;
    assign dmem.dmem_req = (state == S_REQ);

    always_comb begin
        op_illegal = 1'b0;
        op_misal   = 1'b0;
        if (is_store)
            op_illegal = mem_op[2] | (mem_op == 3'b011);
        else
            op_illegal = (mem_op == 3'b011) | (mem_op[2:1] == 2'b11);
        op_misal = ((mem_op[1:0] == 2'b01) & alu_result[0]) |
                   ((mem_op[1:0] == 2'b10) & (|alu_result[1:0]));
    end

    // Lane placement is computed for loads too, so be also marks the bytes read.
    always_comb begin
        acc_be    = 4'b1111;
        acc_wdata = store_data;
        case (mem_op[1:0])
            2'b00: begin
                acc_be    = 4'b0001 << alu_result[1:0];
                acc_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                acc_be    = alu_result[1] ? 4'b1100 : 4'b0011;
                acc_wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        lane   = dmem.dmem_rdata >> {off_q, 3'b000};
        ld_ext = dmem.dmem_rdata;
        case (op_q)
            3'b000:  ld_ext = {{(XLEN-8){lane[7]}}, lane[7:0]};
            3'b001:  ld_ext = {{(XLEN-16){lane[15]}}, lane[15:0]};
            3'b100:  ld_ext = {{(XLEN-8){1'b0}}, lane[7:0]};
            3'b101:  ld_ext = {{(XLEN-16){1'b0}}, lane[15:0]};
            default: ld_ext = dmem.dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (acc && !op_illegal && !op_misal) state_nxt = S_REQ;
            S_REQ:   if (dmem.dmem_gnt) state_nxt = dmem.dmem_we ? S_IDLE : S_WAIT;
            S_WAIT:  if (dmem.dmem_rvalid) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= '0;
            dmem.dmem_be    <= '0;
            dmem.dmem_wdata <= '0;
            op_q            <= '0;
            off_q           <= '0;
            rd_q            <= '0;
            wb_valid        <= 1'b0;
            wb_rd           <= '0;
            wb_data         <= '0;
            exc_valid       <= 1'b0;
            exc_cause       <= '0;
            exc_addr        <= '0;
        end else begin
            exc_valid <= 1'b0;
            wb_valid  <= 1'b0;
            if (acc) begin
                if (op_illegal || op_misal) begin
                    exc_valid <= 1'b1;
                    exc_addr  <= alu_result;
                    if (op_illegal)
                        exc_cause <= 2'b11;
                    else
                        exc_cause <= is_store ? 2'b10 : 2'b01;
                end else begin
                    dmem.dmem_we    <= is_store;
                    dmem.dmem_addr  <= {alu_result[XLEN-1:2], 2'b00};
                    dmem.dmem_be    <= acc_be;
                    dmem.dmem_wdata <= acc_wdata;
                    op_q            <= mem_op;
                    off_q           <= alu_result[1:0];
                    rd_q            <= rd_addr;
                end
            end
            // Only WAIT consumes rvalid; stale responses in IDLE/REQ are dropped.
            if ((state == S_WAIT) && dmem.dmem_rvalid) begin
                wb_valid <= 1'b1;
                wb_rd    <= rd_q;
                wb_data  <= ld_ext;
            end
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Randomized and directed check of lsu against a byte-level reference model.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic        is_store = 1'b0;
    logic [2:0]  mem_op = '0;
    logic [31:0] alu_result = '0;
    logic [31:0] store_data = '0;
    logic [4:0]  rd_addr = '0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exc_valid;
    logic [1:0]  exc_cause;
    logic [31:0] exc_addr;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    lsu_if #(.XLEN(32)) dif ();

    lsu #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .is_store   (is_store),
        .mem_op     (mem_op),
        .alu_result (alu_result),
        .store_data (store_data),
        .rd_addr    (rd_addr),
        .dmem       (dif),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .exc_valid  (exc_valid),
        .exc_cause  (exc_cause),
        .exc_addr   (exc_addr),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int op_size(input logic [2:0] op);
        case (op[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic int exp_cause(input logic st, input logic [2:0] op, input logic [31:0] a);
        bit legal;
        legal = st ? (op inside {3'd0, 3'd1, 3'd2}) : (op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) return 3;
        if ((a % op_size(op)) != 0) return st ? 2 : 1;
        return 0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] op, input logic [31:0] a);
        int sz;
        int b;
        sz = op_size(op);
        b  = ((1 << sz) - 1) << (a % 4);
        return 4'(b);
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] op, input logic [31:0] d);
        logic [31:0] r;
        int sz;
        sz = op_size(op);
        r  = '0;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = d[8*(i % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] rdata);
        logic [31:0] v;
        int sz;
        sz = op_size(op);
        v  = rdata >> (8 * (a % 4));
        if (sz < 4) begin
            v = v & ((32'd1 << (8 * sz)) - 32'd1);
            if (!op[2] && v[8*sz-1])
                v = v - (32'd1 << (8 * sz));
        end
        return v;
    endfunction

    // Junk on ex_* and rvalid while busy; none of it may be accepted.
    task automatic drive_junk(input bit with_rvalid);
        ex_valid   = 1'($urandom_range(0, 1));
        is_store   = 1'($urandom_range(0, 1));
        mem_op     = 3'($urandom_range(0, 7));
        alu_result = $urandom;
        store_data = $urandom;
        rd_addr    = 5'($urandom_range(0, 31));
        dif.dmem_rvalid = with_rvalid ? 1'($urandom_range(0, 1)) : 1'b0;
        dif.dmem_rdata  = $urandom;
    endtask

    task automatic do_op(input logic st, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] rd, input logic [31:0] rdata,
                         input int gdly, input int rdly);
        int cause;
        chk_eq("ready_before_op", 32'(ex_ready), 32'd1);
        ex_valid   = 1'b1;
        is_store   = st;
        mem_op     = op;
        alu_result = a;
        store_data = d;
        rd_addr    = rd;
        tick();
        cause = exp_cause(st, op, a);
        if (cause != 0) begin
            ex_valid = 1'b0;
            chk_eq("exc_valid", 32'(exc_valid), 32'd1);
            chk_eq("exc_cause", 32'(exc_cause), 32'(cause));
            chk_eq("exc_addr", exc_addr, a);
            chk_eq("exc_no_req", 32'(dif.dmem_req), 32'd0);
            chk_eq("exc_ready", 32'(ex_ready), 32'd1);
            tick();
            chk_eq("exc_pulse_end", 32'(exc_valid), 32'd0);
            return;
        end
        chk_eq("busy_after_accept", 32'(busy), 32'd1);
        for (int g = 0; g <= gdly; g++) begin
            chk_eq("req_held", 32'(dif.dmem_req), 32'd1);
            chk_eq("req_we", 32'(dif.dmem_we), 32'(st));
            chk_eq("req_addr", dif.dmem_addr, {a[31:2], 2'b00});
            chk_eq("req_ex_ready", 32'(ex_ready), 32'd0);
            if (st) begin
                chk_eq("req_be", 32'(dif.dmem_be), 32'(exp_be(op, a)));
                chk_eq("req_wdata", dif.dmem_wdata, exp_wdata(op, d));
            end
            if (g < gdly) begin
                drive_junk(1'b1);
                dif.dmem_gnt = 1'b0;
            end else begin
                drive_junk(1'b0);
                dif.dmem_gnt = 1'b1;
            end
            tick();
        end
        dif.dmem_gnt = 1'b0;
        if (st) begin
            ex_valid = 1'b0;
            chk_eq("st_req_drop", 32'(dif.dmem_req), 32'd0);
            chk_eq("st_ready_back", 32'(ex_ready), 32'd1);
            chk_eq("st_no_wb", 32'(wb_valid), 32'd0);
            return;
        end
        chk_eq("ld_req_drop", 32'(dif.dmem_req), 32'd0);
        for (int r = 0; r < rdly; r++) begin
            chk_eq("ld_wait_busy", 32'(ex_ready), 32'd0);
            chk_eq("ld_wait_no_wb", 32'(wb_valid), 32'd0);
            drive_junk(1'b0);
            tick();
        end
        dif.dmem_rvalid = 1'b1;
        dif.dmem_rdata  = rdata;
        tick();
        dif.dmem_rvalid = 1'b0;
        ex_valid        = 1'b0;
        chk_eq("wb_valid", 32'(wb_valid), 32'd1);
        chk_eq("wb_data", wb_data, exp_load(op, a, rdata));
        chk_eq("wb_rd", 32'(wb_rd), 32'(rd));
        chk_eq("ld_ready_back", 32'(ex_ready), 32'd1);
        tick();
        chk_eq("wb_pulse_end", 32'(wb_valid), 32'd0);
    endtask

    task automatic chk_reset_vals();
        chk_eq("rst_ex_ready", 32'(ex_ready), 32'd1);
        chk_eq("rst_busy", 32'(busy), 32'd0);
        chk_eq("rst_req", 32'(dif.dmem_req), 32'd0);
        chk_eq("rst_we", 32'(dif.dmem_we), 32'd0);
        chk_eq("rst_addr", dif.dmem_addr, 32'd0);
        chk_eq("rst_be", 32'(dif.dmem_be), 32'd0);
        chk_eq("rst_wdata", dif.dmem_wdata, 32'd0);
        chk_eq("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk_eq("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk_eq("rst_wb_data", wb_data, 32'd0);
        chk_eq("rst_exc_valid", 32'(exc_valid), 32'd0);
        chk_eq("rst_exc_cause", 32'(exc_cause), 32'd0);
        chk_eq("rst_exc_addr", exc_addr, 32'd0);
    endtask

    initial begin
        logic        st;
        logic [2:0]  op;
        logic [31:0] a;

        dif.dmem_gnt    = 1'b0;
        dif.dmem_rvalid = 1'b0;
        dif.dmem_rdata  = '0;
        #2;
        chk_reset_vals();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk_reset_vals();

        // directed cases
        do_op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd0, 32'h0, 0, 0);
        do_op(1'b1, 3'b000, 32'h103, 32'h000000A5, 5'd0, 32'h0, 1, 0);
        do_op(1'b0, 3'b000, 32'h102, 32'h0, 5'd7, 32'h00807F00, 0, 0);
        do_op(1'b0, 3'b100, 32'h102, 32'h0, 5'd8, 32'h00807F00, 0, 0);
        do_op(1'b0, 3'b001, 32'h102, 32'h0, 5'd9, 32'h00807F00, 0, 0);
        do_op(1'b0, 3'b010, 32'h101, 32'h0, 5'd3, 32'h0, 0, 0);
        do_op(1'b1, 3'b001, 32'h003, 32'h1234, 5'd0, 32'h0, 0, 0);
        do_op(1'b0, 3'b011, 32'h200, 32'h0, 5'd4, 32'h0, 0, 0);
        do_op(1'b0, 3'b101, 32'h20E, 32'h0, 5'd0, 32'hBEEF8001, 5, 3);

        // stale rvalid in IDLE
        dif.dmem_rvalid = 1'b1;
        dif.dmem_rdata  = 32'hFFFF_FFFF;
        tick();
        dif.dmem_rvalid = 1'b0;
        chk_eq("stale_rvalid_no_wb", 32'(wb_valid), 32'd0);
        chk_eq("stale_rvalid_idle", 32'(ex_ready), 32'd1);

        // reset while waiting for load data
        ex_valid   = 1'b1;
        is_store   = 1'b0;
        mem_op     = 3'b010;
        alu_result = 32'h400;
        rd_addr    = 5'd5;
        tick();
        ex_valid     = 1'b0;
        dif.dmem_gnt = 1'b1;
        tick();
        dif.dmem_gnt = 1'b0;
        chk_eq("pre_rst_in_wait", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals();
        tick();
        rst_n           = 1'b1;
        dif.dmem_rvalid = 1'b1;
        dif.dmem_gnt    = 1'b1;
        dif.dmem_rdata  = 32'h5555_AAAA;
        tick();
        dif.dmem_rvalid = 1'b0;
        dif.dmem_gnt    = 1'b0;
        chk_eq("late_rvalid_no_wb", 32'(wb_valid), 32'd0);
        chk_eq("late_gnt_no_req", 32'(dif.dmem_req), 32'd0);
        do_op(1'b0, 3'b010, 32'h400, 32'h0, 5'd5, 32'hCAFEF00D, 0, 0);

        // randomized traffic
        for (int n = 0; n < 250; n++) begin
            st = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0)
                op = 3'($urandom_range(0, 7));
            else if (st)
                op = 3'($urandom_range(0, 2));
            else begin
                op = 3'($urandom_range(0, 4));
                if (op == 3'd3) op = 3'd5;
            end
            a = $urandom;
            if ($urandom_range(0, 1) == 0)
                a[1:0] = 2'b00;
            do_op(st, op, a, $urandom, 5'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit in the memory stage, directly downstream of the execute-stage ALU. It takes the ALU's effective address (`alu_result`, produced by an ADD of rs1 and the immediate) plus rs2 store data and funct3, and runs one handshaked access on the data-memory port. It performs byte-lane alignment, byte-enable generation, and load sign/zero extension, then returns the load result to write-back. Misaligned or illegal accesses raise an exception pulse instead of touching memory.

## Interface
- `XLEN`, 32, data and address width
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `ex_valid`  in  1  EX presents a memory op this cycle
- `ex_ready`  out  1  LSU can accept an op (high only in IDLE)
- `is_store`  in  1  1 = store, 0 = load
- `mem_op`  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
- `alu_result`  in  XLEN  effective byte address
- `store_data`  in  XLEN  rs2 value
- `rd_addr`  in  5  load destination register
- `dmem_req`  out  1  request, held until granted
- `dmem_we`  out  1  write request
- `dmem_addr`  out  XLEN  word-aligned address, `{addr[XLEN-1:2],2'b00}`
- `dmem_be`  out  4  byte enables
- `dmem_wdata`  out  XLEN  lane-replicated store data
- `dmem_gnt`  in  1  request accepted this cycle
- `dmem_rvalid`  in  1  read data valid
- `dmem_rdata`  in  XLEN  read word
- `wb_valid`  out  1  one-cycle load result pulse
- `wb_rd`  out  5  destination register
- `wb_data`  out  XLEN  extended load data
- `exc_valid`  out  1  one-cycle exception pulse
- `exc_cause`  out  2  01 misaligned load, 10 misaligned store, 11 illegal mem_op
- `exc_addr`  out  XLEN  faulting address
- `busy`  out  1  `~ex_ready`

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE, accept (`ex_valid & ex_ready`):
  - Register address, op, data, and rd.
  - Illegal op (load 011/110/111; store with `mem_op[2]=1` or 011) -> stay IDLE, `exc_valid` with cause 11 next cycle.
  - Misaligned (H with `addr[0]`, W with `addr[1:0]!=0`) -> stay IDLE, exception pulse next cycle, cause 01 or 10.
  - Otherwise -> REQ.
- REQ: `dmem_req=1`; address, we, be, and wdata are stable until `dmem_gnt`.
  - On grant, a store returns to IDLE with no `wb_valid`.
  - On grant, a load goes to WAIT.
  - `dmem_rvalid` is ignored in REQ.
- WAIT: on `dmem_rvalid`, register `wb_data`, pulse `wb_valid`, return to IDLE.
- Store byte enables and data:
  - SB: `be = 4'b0001 << addr[1:0]`; wdata = byte replicated ×4.
  - SH: `be = addr[1] ? 1100 : 0011`; wdata = halfword replicated ×2.
  - SW: `be = 1111`; wdata = rs2.
- Load extraction:
  - `lane = rdata >> (8*addr[1:0])`.
  - B/H sign-extend bit 7/15; BU/HU zero-extend; W passes through.
- `rd_addr=0` loads still access memory; `wb_valid` is asserted with `wb_rd=0`.
- `dmem_rvalid` in IDLE (stale) is ignored.
- Reset mid-operation: return to IDLE, drop `dmem_req` immediately. Any later `rvalid`/`gnt` is ignored.

## Timing
- Reset values:
  - state IDLE, `ex_ready=1`, `busy=0`.
  - `dmem_req=0`, `dmem_we=0`, `dmem_addr=0`, `dmem_be=0`, `dmem_wdata=0`.
  - `wb_valid=0`, `wb_rd=0`, `wb_data=0`.
  - `exc_valid=0`, `exc_cause=0`, `exc_addr=0`.
- All outputs are registered. `ex_ready` and `busy` decode from state.
- Accept at cycle T -> `dmem_req` high from T+1.
- Store: gnt at G ≥ T+1 -> `dmem_req` low and `ex_ready` high at G+1. Minimum 2-cycle occupancy.
- Load: gnt at G, rvalid at R ≥ G+1 -> `wb_valid` and `ex_ready` high at R+1. Minimum latency 3 cycles (T to wb_valid at T+3).
- Exception: accept at T -> `exc_valid` pulse at T+1; `ex_ready` stays high. Back-to-back accepts are allowed.
- Unbounded gnt/rvalid stalls hold state with outputs stable.

## Test plan
- SW `0xDEADBEEF` at `0x100`, gnt same cycle as req -> `be=1111`, `addr=0x100`, `wdata=0xDEADBEEF`, `ex_ready` back 2 cycles after accept, no `wb_valid`.
- SB `0x000000A5` at `0x103` -> `be=1000`, `wdata=0xA5A5A5A5`, `addr=0x100`.
- LB at `0x102`, rdata `0x00807F00` -> `wb_data=0xFFFFFF80`. LBU at the same address -> `0x00000080`. LH at `0x102` -> `0x00000080`, `wb_rd` matches `rd_addr`, `wb_valid` exactly 1 cycle.
- LW at `0x101` -> no `dmem_req`, `exc_valid` 1 cycle with cause 01 and `exc_addr=0x101`. SH at `0x003` -> cause 10. Load `mem_op=011` -> cause 11.
- gnt delayed 5 cycles, rvalid 4 cycles after gnt -> req/addr/be stable throughout, `wb_valid` at rvalid+1, `ex_valid` ignored while busy.
- `rst_n` low during WAIT, then late `dmem_rvalid` -> all outputs at reset values, no `wb_valid`, next op accepted normally.
